dcache_direct_mapped: RTL and testbench

- Write-back, write-allocate, direct-mapped data cache; it is the responder on the CPU-side D-cache port (ren/wen/addr/wdata in; stall/rdata out).
- It is the initiator on a 128-bit block-wide memory port.
- Sits between the pipeline's MEM stage and the slow data memory.
- Hits complete combinationally in the request cycle. Misses hold proc_stall high until the block is resident.

---
 rtl/dcache_direct_mapped_if.sv | 27 ++
 rtl/dcache_direct_mapped.sv | 186 ++++++++++++++++++
 tb/tb_dcache_direct_mapped.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_direct_mapped_if.sv
// CPU-side D-cache port and 128-bit block-wide memory port of dcache_direct_mapped.
// slave  : the cache (responder to the CPU, initiator on the memory side).
// master : the surrounding environment (CPU MEM stage plus data memory).
interface dcache_direct_mapped_if;
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic         proc_stall;
    logic [31:0]  proc_rdata;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         mem_ready;
    logic [127:0] mem_rdata;

    modport slave (
        input  proc_read, proc_write, proc_addr, proc_wdata, mem_ready, mem_rdata,
        output proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output proc_read, proc_write, proc_addr, proc_wdata, mem_ready, mem_rdata,
        input  proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dcache_direct_mapped.sv
// Write-back, write-allocate, direct-mapped data cache with 4-word (128-bit) blocks.
// Hits complete combinationally; misses stall the CPU until the block is resident.
// Optional macro DCACHE_PERF_CNT_EN adds saturating hit_cnt/miss_cnt outputs.
module dcache_direct_mapped #(
    parameter int unsigned INDEX_BITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dcache_direct_mapped_if.slave bus
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]           hit_cnt,
    output logic [31:0]           miss_cnt
`endif
);

    localparam int unsigned TAG_W   = 28 - INDEX_BITS;
    localparam int unsigned NUM_BLK = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        StIdle,
        StWriteback,
        StAllocate
    } state_e;

    state_e             r_state;
    state_e             w_state_nxt;

    logic [127:0]       r_data [NUM_BLK];
    logic [TAG_W-1:0]   r_tag  [NUM_BLK];
    logic [NUM_BLK-1:0] r_valid;
    logic [NUM_BLK-1:0] r_dirty;

    logic               r_mem_read;
    logic               r_mem_write;
    logic [27:0]        r_mem_addr;
    logic [127:0]       r_mem_wdata;
    logic               w_mem_read_nxt;
    logic               w_mem_write_nxt;
    logic [27:0]        w_mem_addr_nxt;
    logic [127:0]       w_mem_wdata_nxt;

    logic [1:0]            w_offset;
    logic [INDEX_BITS-1:0] w_index;
    logic [TAG_W-1:0]      w_tag;
    logic                  w_req;
    logic                  w_hit;
    logic                  w_write_hit;
    logic                  w_refill;

    assign w_offset    = bus.proc_addr[1:0];
    assign w_index     = bus.proc_addr[INDEX_BITS+1:2];
    assign w_tag       = bus.proc_addr[29:INDEX_BITS+2];
    assign w_req       = bus.proc_read | bus.proc_write;
    assign w_hit       = r_valid[w_index] & (r_tag[w_index] == w_tag);
    // A write wins when read and write are both asserted.
    assign w_write_hit = (r_state == StIdle) & bus.proc_write & w_hit;
    assign w_refill    = (r_state == StAllocate) & bus.mem_ready;

    assign bus.mem_read  = r_mem_read;
    assign bus.mem_write = r_mem_write;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;

    // CPU-side outputs: stall on a miss in IDLE, always stall while a miss is in flight.
    always_comb begin
        bus.proc_stall = 1'b1;
        if (r_state == StIdle) begin
            bus.proc_stall = w_req & ~w_hit;
        end
        bus.proc_rdata = r_data[w_index][{w_offset, 5'b0} +: 32];
    end

    // Next-state and next memory-request values.
    always_comb begin
        w_state_nxt     = r_state;
        w_mem_read_nxt  = r_mem_read;
        w_mem_write_nxt = r_mem_write;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        unique case (r_state)
            StIdle: begin
                if (w_req && !w_hit) begin
                    if (r_valid[w_index] && r_dirty[w_index]) begin
                        w_state_nxt     = StWriteback;
                        w_mem_write_nxt = 1'b1;
                        w_mem_addr_nxt  = {r_tag[w_index], w_index};
                        w_mem_wdata_nxt = r_data[w_index];
                    end else begin
                        w_state_nxt    = StAllocate;
                        w_mem_read_nxt = 1'b1;
                        w_mem_addr_nxt = {w_tag, w_index};
                    end
                end
            end
            StWriteback: begin
                if (bus.mem_ready) begin
                    w_state_nxt     = StAllocate;
                    w_mem_write_nxt = 1'b0;
                    w_mem_read_nxt  = 1'b1;
                    w_mem_addr_nxt  = {w_tag, w_index};
                end
            end
            StAllocate: begin
                if (bus.mem_ready) begin
                    w_state_nxt    = StIdle;
                    w_mem_read_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // State and registered memory-port outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_mem_read  <= w_mem_read_nxt;
            r_mem_write <= w_mem_write_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
        end
    end

    // Valid/dirty bits: cleared by reset, set on refill, dirty on a write hit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (w_refill) begin
            r_valid[w_index] <= 1'b1;
            r_dirty[w_index] <= 1'b0;
        end else if (w_write_hit) begin
            r_dirty[w_index] <= 1'b1;
        end
    end

    // Tag/data arrays are not reset, but reset still suppresses any pending update.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (w_refill) begin
                r_data[w_index] <= bus.mem_rdata;
                r_tag[w_index]  <= w_tag;
            end else if (w_write_hit) begin
                r_data[w_index][{w_offset, 5'b0} +: 32] <= bus.proc_wdata;
            end
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;
    logic        r_after_alloc;

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;

    // Saturating counters; the first IDLE cycle after a refill completes the miss,
    // so it is not counted as a hit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hit_cnt     <= '0;
            r_miss_cnt    <= '0;
            r_after_alloc <= 1'b0;
        end else begin
            r_after_alloc <= w_refill;
            if ((r_state == StIdle) && (w_state_nxt != StIdle) && (r_miss_cnt != 32'hFFFF_FFFF)) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
            if ((r_state == StIdle) && w_req && w_hit && !r_after_alloc &&
                (r_hit_cnt != 32'hFFFF_FFFF)) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// Directed self-checking bench for dcache_direct_mapped (INDEX_BITS = 3).
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
module tb_dcache_direct_mapped;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   n_wr_cycles;

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    dcache_direct_mapped_if u_if ();

    dcache_direct_mapped #(
        .INDEX_BITS (3)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (u_if.slave)
`ifdef DCACHE_PERF_CNT_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    localparam logic [127:0] BlkA  = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};
    localparam logic [127:0] BlkA2 = {32'h3333_3333, 32'h2222_2222, 32'h1234_5678, 32'hDEAD_BEEF};
    localparam logic [127:0] BlkB  = {32'h4444_4444, 32'h5555_5555, 32'h6666_6666, 32'hCAFE_F00D};
    localparam logic [127:0] Junk  = {4{32'hBAD0_BAD0}};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count cycles with mem_write asserted, to prove a clean miss never writes back.
    initial n_wr_cycles = 0;
    always @(negedge clk) begin
        if (u_if.mem_write === 1'b1) n_wr_cycles <= n_wr_cycles + 1;
    end

    task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [29:0] a, input logic [31:0] d);
        u_if.proc_read  = rd;
        u_if.proc_write = wr;
        u_if.proc_addr  = a;
        u_if.proc_wdata = d;
    endtask

    // Memory model: answer the outstanding request after lat cycles with a one-cycle pulse.
    task automatic mem_respond(input int lat, input logic [127:0] blk);
        repeat (lat) cyc();
        u_if.mem_ready = 1'b1;
        u_if.mem_rdata = blk;
        cyc();
        u_if.mem_ready = 1'b0;
        u_if.mem_rdata = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_before;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 30'h0, 32'h0);
        u_if.mem_ready = 1'b0;
        u_if.mem_rdata = '0;

        // Reset state
        repeat (2) cyc();
        @(negedge clk);
        check_val("rst_mem_read", u_if.mem_read, 1'b0);
        check_val("rst_mem_write", u_if.mem_write, 1'b0);
        check_val("rst_mem_addr", u_if.mem_addr, 28'h0);
        check_val("rst_mem_wdata", u_if.mem_wdata, 128'h0);
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        check_val("idle_no_stall", u_if.proc_stall, 1'b0);

        // Clean miss on 0x10: index 4, tag 0
        wr_before = n_wr_cycles;
        cyc();
        drive(1'b1, 1'b0, 30'h10, 32'h0);
        @(negedge clk);
        check_val("miss1_stall", u_if.proc_stall, 1'b1);
        cyc();
        @(negedge clk);
        check_val("miss1_mem_read", u_if.mem_read, 1'b1);
        check_val("miss1_mem_addr", u_if.mem_addr, 28'h4);
        check_val("miss1_alloc_stall", u_if.proc_stall, 1'b1);
        mem_respond(4, BlkA);
        @(negedge clk);
        check_val("miss1_done_stall", u_if.proc_stall, 1'b0);
        check_val("miss1_rdata", u_if.proc_rdata, 32'hDEAD_BEEF);
        check_val("miss1_read_drop", u_if.mem_read, 1'b0);
        check_val("miss1_no_wb", n_wr_cycles - wr_before, 0);

        // Write hit to word 1, then read it back with zero latency
        cyc();
        drive(1'b0, 1'b1, 30'h11, 32'h1234_5678);
        @(negedge clk);
        check_val("wr_hit_stall", u_if.proc_stall, 1'b0);
        cyc();
        drive(1'b1, 1'b0, 30'h11, 32'h0);
        @(negedge clk);
        check_val("rd_after_wr_stall", u_if.proc_stall, 1'b0);
        check_val("rd_after_wr_data", u_if.proc_rdata, 32'h1234_5678);

        // Dirty eviction: 0x30 is index 4, tag 1
        cyc();
        drive(1'b1, 1'b0, 30'h30, 32'h0);
        @(negedge clk);
        check_val("evict1_stall", u_if.proc_stall, 1'b1);
        cyc();
        @(negedge clk);
        check_val("evict1_mem_write", u_if.mem_write, 1'b1);
        check_val("evict1_mem_read", u_if.mem_read, 1'b0);
        check_val("evict1_mem_addr", u_if.mem_addr, 28'h4);
        check_val("evict1_wdata_w1", u_if.mem_wdata[63:32], 32'h1234_5678);
        check_val("evict1_wdata_w0", u_if.mem_wdata[31:0], 32'hDEAD_BEEF);
        mem_respond(2, Junk);
        @(negedge clk);
        check_val("evict1_wr_drop", u_if.mem_write, 1'b0);
        check_val("evict1_rd_req", u_if.mem_read, 1'b1);
        check_val("evict1_rd_addr", u_if.mem_addr, 28'hC);
        check_val("evict1_alloc_stall", u_if.proc_stall, 1'b1);
        mem_respond(3, BlkB);
        @(negedge clk);
        check_val("evict1_done_stall", u_if.proc_stall, 1'b0);
        check_val("evict1_rdata", u_if.proc_rdata, 32'hCAFE_F00D);

        // Read and write together on a hit: acts as a write
        cyc();
        drive(1'b1, 1'b1, 30'h31, 32'hA5A5_A5A5);
        @(negedge clk);
        check_val("rw_hit_stall", u_if.proc_stall, 1'b0);
        cyc();
        drive(1'b1, 1'b0, 30'h31, 32'h0);
        @(negedge clk);
        check_val("rw_readback", u_if.proc_rdata, 32'hA5A5_A5A5);

        // Evict it back out via 0x10 and confirm the merged word is written back
        cyc();
        drive(1'b1, 1'b0, 30'h10, 32'h0);
        @(negedge clk);
        check_val("evict2_stall", u_if.proc_stall, 1'b1);
        cyc();
        @(negedge clk);
        check_val("evict2_mem_write", u_if.mem_write, 1'b1);
        check_val("evict2_mem_addr", u_if.mem_addr, 28'hC);
        check_val("evict2_wdata_w1", u_if.mem_wdata[63:32], 32'hA5A5_A5A5);
        check_val("evict2_wdata_w3", u_if.mem_wdata[127:96], 32'h4444_4444);
        mem_respond(1, Junk);
        @(negedge clk);
        check_val("evict2_rd_req", u_if.mem_read, 1'b1);
        check_val("evict2_rd_addr", u_if.mem_addr, 28'h4);
        mem_respond(1, BlkA2);
        @(negedge clk);
        check_val("evict2_done_stall", u_if.proc_stall, 1'b0);
        check_val("evict2_rdata", u_if.proc_rdata, 32'hDEAD_BEEF);

        // Stray mem_ready while idle must not touch the arrays
        cyc();
        drive(1'b0, 1'b0, 30'h10, 32'h0);
        u_if.mem_ready = 1'b1;
        u_if.mem_rdata = {4{32'hFFFF_FFFF}};
        cyc();
        u_if.mem_ready = 1'b0;
        u_if.mem_rdata = '0;
        drive(1'b1, 1'b0, 30'h11, 32'h0);
        @(negedge clk);
        check_val("stray_rdy_stall", u_if.proc_stall, 1'b0);
        check_val("stray_rdy_rdata", u_if.proc_rdata, 32'h1234_5678);
        check_val("stray_rdy_no_req", u_if.mem_read, 1'b0);

        // Reset while waiting in ALLOCATE: 0x50 is index 4, tag 2 (victim is clean)
        cyc();
        drive(1'b1, 1'b0, 30'h50, 32'h0);
        @(negedge clk);
        check_val("rstalloc_stall", u_if.proc_stall, 1'b1);
        cyc();
        @(negedge clk);
        check_val("rstalloc_mem_read", u_if.mem_read, 1'b1);
        check_val("rstalloc_mem_addr", u_if.mem_addr, 28'h14);
        check_val("rstalloc_no_wb", u_if.mem_write, 1'b0);
        cyc();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 30'h0, 32'h0);
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rstalloc_read_drop", u_if.mem_read, 1'b0);
        check_val("rstalloc_addr_clr", u_if.mem_addr, 28'h0);
        check_val("rstalloc_idle", u_if.proc_stall, 1'b0);
        cyc();
        drive(1'b1, 1'b0, 30'h10, 32'h0);
        @(negedge clk);
        check_val("post_rst_miss", u_if.proc_stall, 1'b1);
        cyc();
        @(negedge clk);
        check_val("post_rst_mem_read", u_if.mem_read, 1'b1);
        check_val("post_rst_mem_write", u_if.mem_write, 1'b0);
        check_val("post_rst_mem_addr", u_if.mem_addr, 28'h4);
        mem_respond(2, BlkA2);
        @(negedge clk);
        check_val("post_rst_rdata", u_if.proc_rdata, 32'hDEAD_BEEF);
        // Hold the read: first IDLE cycle completes the miss, then three hit cycles
        repeat (4) cyc();
        drive(1'b0, 1'b0, 30'h10, 32'h0);
        @(negedge clk);
        check_val("post_rst_still_hit", u_if.proc_stall, 1'b0);
`ifdef DCACHE_PERF_CNT_EN
        check_val("perf_miss_cnt", miss_cnt, 32'd1);
        check_val("perf_hit_cnt", hit_cnt, 32'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
